// File: rtl/pipe_seq_pkg.sv
// Shared types for the pipeline sequencer.
// State encoding and arbitration cause codes.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_e;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_MEM    = 3'd1;
  localparam logic [2:0] CAUSE_BRANCH = 3'd2;
  localparam logic [2:0] CAUSE_LDUSE  = 3'd3;
  localparam logic [2:0] CAUSE_IFETCH = 3'd4;
  localparam logic [2:0] CAUSE_HALT   = 3'd5;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear beats increment; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush sequencer for the 5-stage core.
// Mealy controls, mem-wait timeout, perf counters.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HZld,
  input  logic             br_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_rdy,
  input  logic             imem_rdy,
  input  logic             cnt_clr,
  output logic             PC_ld,
  output logic             IF_ID_ld,
  output logic             IF_ID_flush,
  output logic             ID_EX_ld,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_ld,
  output logic             MEM_WB_ld,
  output logic             MEM_WB_bubble,
  output logic [2:0]       cause,
  output logic             halted,
  output logic [CNT_W-1:0] ldu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mw_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          halted_q, halted_d;

  logic mem_stall;
  logic sel_mem, sel_br, sel_ldu, sel_if, sel_none;
  logic run_ok;
  logic [WW-1:0] wait_nxt;

  // one-hot arbitration, highest priority first
  assign mem_stall = mem_req_MEM && !mem_rdy;
  assign sel_mem   = mem_stall;
  assign sel_br    = !mem_stall && br_taken_EX;
  assign sel_ldu   = !mem_stall && !br_taken_EX && !HZld;
  assign sel_if    = !mem_stall && !br_taken_EX && HZld
                     && !imem_rdy;
  assign sel_none  = !mem_stall && !br_taken_EX && HZld
                     && imem_rdy;
  assign run_ok    = RST_N && (state_q != ST_HALT);

  // control outputs act in the same cycle as the request
  always_comb begin
    PC_ld         = 1'b1;
    IF_ID_ld      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_ld      = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_ld     = 1'b1;
    MEM_WB_ld     = 1'b1;
    MEM_WB_bubble = 1'b0;
    cause         = CAUSE_NONE;
    if (!run_ok) begin
      PC_ld         = 1'b0;
      IF_ID_ld      = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_ld      = 1'b0;
      ID_EX_bubble  = 1'b1;
      EX_MEM_ld     = 1'b0;
      MEM_WB_ld     = 1'b0;
      MEM_WB_bubble = 1'b1;
      cause = RST_N ? CAUSE_HALT : CAUSE_NONE;
    end else begin
      unique case (1'b1)
        sel_mem: begin
          PC_ld         = 1'b0;
          IF_ID_ld      = 1'b0;
          ID_EX_ld      = 1'b0;
          EX_MEM_ld     = 1'b0;
          MEM_WB_bubble = 1'b1;
          cause         = CAUSE_MEM;
        end
        sel_br: begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
          cause        = CAUSE_BRANCH;
        end
        sel_ldu: begin
          PC_ld        = 1'b0;
          IF_ID_ld     = 1'b0;
          ID_EX_bubble = 1'b1;
          cause        = CAUSE_LDUSE;
        end
        sel_if: begin
          PC_ld       = 1'b0;
          IF_ID_flush = 1'b1;
          cause       = CAUSE_IFETCH;
        end
        sel_none: cause = CAUSE_NONE;
        default:  cause = CAUSE_NONE;
      endcase
    end
  end

  // wait-count candidate: 1 on entry, saturating step while waiting
  always_comb begin
    wait_nxt = WW'(1);
    if (state_q == ST_MEM_WAIT)
      wait_nxt = (wait_q == '1) ? wait_q : wait_q + 1'b1;
  end

  // sequencing state, timeout tracking and sticky halt
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    if (state_q != ST_HALT) begin
      if (mem_stall) begin
        wait_d  = wait_nxt;
        state_d = ST_MEM_WAIT;
        if ((MEM_TIMEOUT != 0) && (wait_nxt == TO)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end else begin
        wait_d  = '0;
        state_d = ST_RUN;
      end
    end
  end

  // state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  sat_counter #(.W(CNT_W)) u_ldu_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .inc   (run_ok && sel_ldu),
    .cnt   (ldu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .inc   (run_ok && sel_br),
    .cnt   (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .inc   (run_ok && sel_mem),
    .cnt   (mw_cnt)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer.
// Directed vectors, queued expectations, negedge monitor.
module tb_pipeline_sequencer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic HZld = 1'b1;
  logic br_taken_EX = 1'b0;
  logic mem_req_MEM = 1'b0;
  logic mem_rdy = 1'b0;
  logic imem_rdy = 1'b1;
  logic cnt_clr = 1'b0;
  logic PC_ld, IF_ID_ld, IF_ID_flush, ID_EX_ld;
  logic ID_EX_bubble, EX_MEM_ld, MEM_WB_ld, MEM_WB_bubble;
  logic [2:0] cause;
  logic halted;
  logic [1:0] ldu_cnt, br_cnt, mw_cnt;

  pipeline_sequencer #(
    .MEM_TIMEOUT (4),
    .CNT_W       (2)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .HZld          (HZld),
    .br_taken_EX   (br_taken_EX),
    .mem_req_MEM   (mem_req_MEM),
    .mem_rdy       (mem_rdy),
    .imem_rdy      (imem_rdy),
    .cnt_clr       (cnt_clr),
    .PC_ld         (PC_ld),
    .IF_ID_ld      (IF_ID_ld),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EX_ld      (ID_EX_ld),
    .ID_EX_bubble  (ID_EX_bubble),
    .EX_MEM_ld     (EX_MEM_ld),
    .MEM_WB_ld     (MEM_WB_ld),
    .MEM_WB_bubble (MEM_WB_bubble),
    .cause         (cause),
    .halted        (halted),
    .ldu_cnt       (ldu_cnt),
    .br_cnt        (br_cnt),
    .mw_cnt        (mw_cnt)
  );

  always #5 CLK = ~CLK;

  // {PC,IFID,IFflush,IDEX,IDbub,EXMEM,MEMWB,MWbub}
  localparam logic [7:0] C_RST  = 8'b00101001;
  localparam logic [7:0] C_HALT = 8'b00101001;
  localparam logic [7:0] C_NONE = 8'b11010110;
  localparam logic [7:0] C_MEM  = 8'b00000011;
  localparam logic [7:0] C_BR   = 8'b11111110;
  localparam logic [7:0] C_LDU  = 8'b00011110;
  localparam logic [7:0] C_IF   = 8'b01110110;

  typedef struct packed {
    logic [7:0] ctl;
    logic [2:0] cause;
    logic       halted;
    logic [1:0] ldu;
    logic [1:0] br;
    logic [1:0] mw;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_vec   = 0;

  task automatic check(input string nm, input int idx,
                       input logic [7:0] act,
                       input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%h want=%h",
               nm, idx, act, req);
    end
  endtask

  task automatic step(
    input logic rst, hz, br, mreq, mrdy, irdy, clr,
    input logic [7:0] ctl, input logic [2:0] c,
    input logic h, input logic [1:0] l, b, m);
    exp_t e;
    @(posedge CLK);
    #1;
    RST_N       = rst;
    HZld        = hz;
    br_taken_EX = br;
    mem_req_MEM = mreq;
    mem_rdy     = mrdy;
    imem_rdy    = irdy;
    cnt_clr     = clr;
    e.ctl    = ctl;
    e.cause  = c;
    e.halted = h;
    e.ldu    = l;
    e.br     = b;
    e.mw     = m;
    e.idx    = n_vec;
    n_vec++;
    sb.push_back(e);
  endtask

  // monitor: outputs are valid every cycle, compare mid-cycle
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ctl", e.idx,
            {PC_ld, IF_ID_ld, IF_ID_flush, ID_EX_ld,
             ID_EX_bubble, EX_MEM_ld, MEM_WB_ld,
             MEM_WB_bubble}, e.ctl);
      check("cause", e.idx, {5'd0, cause}, {5'd0, e.cause});
      check("halted", e.idx, {7'd0, halted}, {7'd0, e.halted});
      check("ldu_cnt", e.idx, {6'd0, ldu_cnt}, {6'd0, e.ldu});
      check("br_cnt", e.idx, {6'd0, br_cnt}, {6'd0, e.br});
      check("mw_cnt", e.idx, {6'd0, mw_cnt}, {6'd0, e.mw});
    end
  end

  initial begin
    int guard;
    // reset held, idle inputs
    step(0,1,0,0,0,1,0, C_RST,0,0,0,0,0);
    step(0,1,0,0,0,1,0, C_RST,0,0,0,0,0);
    step(1,1,0,0,0,1,0, C_NONE,0,0,0,0,0);
    // load-use for two cycles
    step(1,0,0,0,0,1,0, C_LDU,3,0,0,0,0);
    step(1,0,0,0,0,1,0, C_LDU,3,0,1,0,0);
    step(1,1,0,0,0,1,0, C_NONE,0,0,2,0,0);
    // branch beats load-use and ifetch
    step(1,0,1,0,0,0,0, C_BR,2,0,2,0,0);
    step(1,1,0,0,0,1,0, C_NONE,0,0,2,1,0);
    // ifetch wait
    step(1,1,0,0,0,0,0, C_IF,4,0,2,1,0);
    // 3 mem-wait cycles, suppressed causes not counted
    step(1,1,0,1,0,1,0, C_MEM,1,0,2,1,0);
    step(1,0,1,1,0,0,0, C_MEM,1,0,2,1,1);
    step(1,1,0,1,0,1,0, C_MEM,1,0,2,1,2);
    // rdy cycle arbitrated normally
    step(1,0,0,1,1,1,0, C_LDU,3,0,2,1,3);
    step(1,1,0,0,0,1,0, C_NONE,0,0,3,1,3);
    // saturation
    for (int i = 0; i < 5; i++)
      step(1,0,0,0,0,1,0, C_LDU,3,0,3,1,3);
    // clear beats increment
    step(1,0,0,0,0,1,1, C_LDU,3,0,3,1,3);
    step(1,1,0,0,0,1,0, C_NONE,0,0,0,0,0);
    // timeout after 4 wait cycles
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,0);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,1);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,2);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,3);
    step(1,1,0,1,0,1,0, C_HALT,5,1,0,0,3);
    step(1,1,0,1,1,1,0, C_HALT,5,1,0,0,3);
    step(1,0,1,0,0,1,0, C_HALT,5,1,0,0,3);
    // only reset leaves halt
    step(0,1,0,0,0,1,0, C_RST,0,0,0,0,0);
    step(1,1,0,0,0,1,0, C_NONE,0,0,0,0,0);
    // rdy on the timeout edge wins
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,0);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,1);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,2);
    step(1,1,0,1,1,1,0, C_NONE,0,0,0,0,3);
    step(1,1,0,1,0,1,0, C_MEM,1,0,0,0,3);
    step(1,1,0,0,0,1,0, C_NONE,0,0,0,0,3);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central sequencing controller for the 5-stage ARM pipeline.
- Each cycle it arbitrates between four stall/flush causes:
  - data-memory wait
  - branch-taken flush
  - load-use stall (from the hazard unit)
  - instruction-fetch wait
- Drives load/flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks memory-wait timeout (halts the core on expiry) and keeps saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16: consecutive data-memory stall cycles before HALT; 0 disables the timeout.
- CNT_W, 16: width of each performance counter.

Ports:
- CLK  input  1  pipeline clock.
- RST_N  input  1  asynchronous active-low reset.
- HZld  input  1  hazard-unit load-use stall; 0 = stall requested.
- br_taken_EX  input  1  branch in EX resolved taken.
- mem_req_MEM  input  1  instruction in MEM accesses data memory.
- mem_rdy  input  1  data memory completes the access this cycle.
- imem_rdy  input  1  instruction memory returns a valid fetch this cycle.
- cnt_clr  input  1  synchronous clear of all performance counters.
- PC_ld  output  1  PC register load enable.
- IF_ID_ld  output  1  IF/ID load enable.
- IF_ID_flush  output  1  IF/ID loads a NOP instead of the fetched word.
- ID_EX_ld  output  1  ID/EX load enable.
- ID_EX_bubble  output  1  ID/EX loads a NOP; control-unit mux select.
- EX_MEM_ld  output  1  EX/MEM load enable.
- MEM_WB_ld  output  1  MEM/WB load enable.
- MEM_WB_bubble  output  1  MEM/WB loads a NOP.
- cause  output  3  winning cause: 0 NONE, 1 MEM, 2 BRANCH, 3 LDUSE, 4 IFETCH, 5 HALT.
- halted  output  1  sticky: memory timeout occurred.
- ldu_cnt  output  CNT_W  load-use stall cycles.
- br_cnt  output  CNT_W  branch flushes.
- mw_cnt  output  CNT_W  data-memory wait cycles.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State RUN, wait_cnt=0, all counters 0, halted=0.
  - While reset is asserted: all *_ld=0; IF_ID_flush, ID_EX_bubble and MEM_WB_bubble = 1; cause=0.
- Control outputs are combinational from the registered state and current inputs (Mealy), so they act the same cycle. Counters, wait_cnt, state and halted are registered.
- States: RUN, MEM_WAIT, HALT. Controls are identical in RUN and MEM_WAIT; MEM_WAIT only gates the timeout counter.
- Priority, evaluated every non-HALT cycle; the first match wins:
  - 1 MEM (mem_req_MEM && !mem_rdy):
    - PC, IF/ID, ID/EX, EX/MEM ld=0.
    - MEM_WB_ld=1, MEM_WB_bubble=1.
    - Branch and load-use requests are ignored; they persist because their stages are held.
  - 2 BRANCH (br_taken_EX):
    - All ld=1, IF_ID_flush=1, ID_EX_bubble=1.
    - PC_ld=1 even when imem_rdy=0; the in-flight fetch is discarded.
  - 3 LDUSE (!HZld):
    - PC_ld=0, IF_ID_ld=0, ID_EX_bubble=1.
    - ID_EX_ld, EX_MEM_ld, MEM_WB_ld = 1.
  - 4 IFETCH (!imem_rdy):
    - PC_ld=0, IF_ID_ld=1, IF_ID_flush=1.
    - Back end advances.
  - 5 NONE: all ld=1, no flush or bubble.
- Transitions:
  - RUN→MEM_WAIT on a MEM cycle; wait_cnt:=1.
  - MEM_WAIT, mem_rdy=0: wait_cnt++. If wait_cnt==MEM_TIMEOUT (and MEM_TIMEOUT≠0), go to HALT and set halted=1.
  - MEM_WAIT, mem_rdy=1: back to RUN, wait_cnt:=0. That cycle is arbitrated normally from priority 2 down.
  - mem_rdy=1 on the same edge the timeout would fire: rdy wins, no HALT.
- HALT:
  - All ld=0; all flush/bubble = 1; cause=5.
  - Exits only on reset. Counters freeze.
- Counters:
  - Increment once per cycle of their cause: ldu_cnt on LDUSE, br_cnt on BRANCH, mw_cnt on MEM.
  - Each saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment in the same cycle.
  - A suppressed lower-priority cause is not counted.

Decomposition:
- Package pipe_seq_pkg holds:
  - state enum: RUN, MEM_WAIT, HALT.
  - cause code constants, 3 bits.
- Sub-module sat_counter (param W; inputs clr, inc; async active-low reset), instantiated three times.

Test Plan:
- Reset with all inputs idle (HZld=1, imem_rdy=1, mem_req_MEM=0) -> all ld=1, cause=0, counters 0.
- HZld=0 for 2 cycles -> PC_ld=0, IF_ID_ld=0, ID_EX_bubble=1 on both cycles; ldu_cnt=2, cause=3.
- br_taken_EX=1 with HZld=0 and imem_rdy=0 in the same cycle -> BRANCH wins: PC_ld=1, IF_ID_flush=1, ID_EX_bubble=1; br_cnt=1, ldu_cnt unchanged.
- mem_req_MEM=1 with mem_rdy=0 for 3 cycles, then mem_rdy=1 -> front four ld=0 and MEM_WB_bubble=1 for 3 cycles; mw_cnt=3; state back to RUN; 4th cycle all ld=1.
- MEM_TIMEOUT=4, mem_rdy held 0 -> after 4 wait cycles halted=1, all ld=0, cause=5; later mem_rdy=1 has no effect until RST_N pulses low.
- CNT_W=2: 5 load-use cycles -> ldu_cnt stays 3. Then cnt_clr=1 together with HZld=0 -> ldu_cnt=0 next cycle.
